// File: rtl/teclado_atm.sv
// Keypad front-end for the ATM controller: debounces raw key presses, emits PIN
// digit strobes, and accumulates decimal amount digits into a binary MONTO.
module teclado_atm #(
  parameter int unsigned DEBOUNCE_CICLOS   = 4,
  parameter int unsigned MAX_DIGITOS_MONTO = 9
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TECLA_PRESIONADA,
  input  logic [3:0]  TECLA,
  input  logic        MODO_MONTO,
  output logic        DIGITO_STB,
  output logic [3:0]  DIGITO,
  output logic        MONTO_STB,
  output logic [31:0] MONTO,
  output logic        DESBORDE
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int unsigned NW = $clog2(MAX_DIGITOS_MONTO + 1);
  localparam logic [CW-1:0] CNT_ULT  = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [NW-1:0] NUM_MAX  = NW'(MAX_DIGITOS_MONTO);
  localparam logic [3:0]    K_ENTER  = 4'hA;
  localparam logic [3:0]    K_BORRAR = 4'hB;

  typedef enum logic [1:0] {ESPERA, FILTRO, ACEPTADA, LIBERA} estado_t;

  estado_t        estado;
  logic [CW-1:0]  cnt;
  logic [3:0]     tecla_q;
  logic           modo_q;
  logic [31:0]    acc;
  logic [NW-1:0]  num;

  logic           cambio_modo;
  logic           evento;
  logic           es_digito;
  logic [31:0]    acc_base;
  logic [31:0]    acc_sig;
  logic [NW-1:0]  num_base;

  // A mode change clears the accumulator on the same edge an event may use it.
  always_comb begin
    cambio_modo = (MODO_MONTO != modo_q);
    acc_base    = cambio_modo ? '0 : acc;
    num_base    = cambio_modo ? '0 : num;
    evento      = (estado == FILTRO) && TECLA_PRESIONADA &&
                  (TECLA == tecla_q) && (cnt == CNT_ULT);
    es_digito   = (tecla_q <= 4'd9);
    acc_sig     = (acc_base << 3) + (acc_base << 1) + {28'd0, tecla_q};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      estado     <= ESPERA;
      cnt        <= '0;
      tecla_q    <= '0;
      modo_q     <= 1'b0;
      acc        <= '0;
      num        <= '0;
      DIGITO_STB <= 1'b0;
      DIGITO     <= '0;
      MONTO_STB  <= 1'b0;
      MONTO      <= '0;
      DESBORDE   <= 1'b0;
    end else begin
      DIGITO_STB <= 1'b0;
      MONTO_STB  <= 1'b0;
      DESBORDE   <= 1'b0;
      modo_q     <= MODO_MONTO;
      acc        <= acc_base;
      num        <= num_base;

      case (estado)
        ESPERA: begin
          if (TECLA_PRESIONADA) begin
            estado  <= FILTRO;
            tecla_q <= TECLA;
            cnt     <= CW'(1);
          end
        end
        FILTRO: begin
          if (!TECLA_PRESIONADA) begin
            estado <= ESPERA;
          end else if (TECLA != tecla_q) begin
            tecla_q <= TECLA;
            cnt     <= CW'(1);
          end else if (cnt == CNT_ULT) begin
            estado <= ACEPTADA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACEPTADA: begin
          if (!TECLA_PRESIONADA) begin
            estado <= LIBERA;
            cnt    <= CW'(1);
          end
        end
        LIBERA: begin
          if (TECLA_PRESIONADA) begin
            estado <= ACEPTADA;
          end else if (cnt == CNT_ULT) begin
            estado <= ESPERA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: estado <= ESPERA;
      endcase

      // Accepted key: PIN mode forwards digits, amount mode edits the accumulator.
      if (evento) begin
        if (!MODO_MONTO) begin
          if (es_digito) begin
            DIGITO     <= tecla_q;
            DIGITO_STB <= 1'b1;
          end
        end else if (es_digito) begin
          if (num_base == NUM_MAX) begin
            DESBORDE <= 1'b1;
          end else begin
            acc <= acc_sig;
            num <= num_base + 1'b1;
          end
        end else if (tecla_q == K_ENTER) begin
          if (num_base != '0) begin
            MONTO     <= acc_base;
            MONTO_STB <= 1'b1;
            acc       <= '0;
            num       <= '0;
          end
        end else if (tecla_q == K_BORRAR) begin
          acc <= '0;
          num <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_atm.sv
// Directed bench for teclado_atm: key-press vector table plus hand-written
// sequences for latency, bounce, glitch and reset-during-filter cases.
module tb_teclado_atm;

  localparam int DEB = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TECLA_PRESIONADA;
  logic [3:0]  TECLA;
  logic        MODO_MONTO;
  logic        DIGITO_STB;
  logic [3:0]  DIGITO;
  logic        MONTO_STB;
  logic [31:0] MONTO;
  logic        DESBORDE;

  teclado_atm #(.DEBOUNCE_CICLOS(DEB), .MAX_DIGITOS_MONTO(9)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .TECLA_PRESIONADA (TECLA_PRESIONADA),
    .TECLA            (TECLA),
    .MODO_MONTO       (MODO_MONTO),
    .DIGITO_STB       (DIGITO_STB),
    .DIGITO           (DIGITO),
    .MONTO_STB        (MONTO_STB),
    .MONTO            (MONTO),
    .DESBORDE         (DESBORDE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        modo;
    logic [3:0]  tecla;
    int          nd;
    int          nm;
    int          no;
    logic [3:0]  dig;
    logic [31:0] monto;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   multi  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (int'(DIGITO_STB) + int'(MONTO_STB) + int'(DESBORDE) > 1) multi++;
  endtask

  task automatic press(input logic modo, input logic [3:0] k, input int hold,
                       output int nd, output int nm, output int no);
    nd = 0; nm = 0; no = 0;
    MODO_MONTO = modo;
    TECLA = k;
    TECLA_PRESIONADA = 1'b1;
    repeat (hold) begin
      step();
      nd += int'(DIGITO_STB); nm += int'(MONTO_STB); no += int'(DESBORDE);
    end
    TECLA_PRESIONADA = 1'b0;
    repeat (DEB + 2) begin
      step();
      nd += int'(DIGITO_STB); nm += int'(MONTO_STB); no += int'(DESBORDE);
    end
  endtask

  initial begin
    int nd, nm, no, first;

    // key-press table: mode, key, expected strobe counts, DIGITO, MONTO afterwards
    vecs.push_back('{1'b0, 4'd7, 1, 0, 0, 4'd7, 32'd0});
    vecs.push_back('{1'b0, 4'd0, 1, 0, 0, 4'd0, 32'd0});
    vecs.push_back('{1'b0, 4'hA, 0, 0, 0, 4'd0, 32'd0});
    vecs.push_back('{1'b0, 4'd9, 1, 0, 0, 4'd9, 32'd0});
    vecs.push_back('{1'b1, 4'd1, 0, 0, 0, 4'd9, 32'd0});
    vecs.push_back('{1'b1, 4'd2, 0, 0, 0, 4'd9, 32'd0});
    vecs.push_back('{1'b1, 4'd5, 0, 0, 0, 4'd9, 32'd0});
    vecs.push_back('{1'b1, 4'd0, 0, 0, 0, 4'd9, 32'd0});
    vecs.push_back('{1'b1, 4'hA, 0, 1, 0, 4'd9, 32'd1250});
    vecs.push_back('{1'b1, 4'hA, 0, 0, 0, 4'd9, 32'd1250});
    vecs.push_back('{1'b1, 4'hC, 0, 0, 0, 4'd9, 32'd1250});
    for (int i = 0; i < 9; i++) vecs.push_back('{1'b1, 4'd9, 0, 0, 0, 4'd9, 32'd1250});
    vecs.push_back('{1'b1, 4'd9, 0, 0, 1, 4'd9, 32'd1250});
    vecs.push_back('{1'b1, 4'hA, 0, 1, 0, 4'd9, 32'd999999999});
    vecs.push_back('{1'b1, 4'd4, 0, 0, 0, 4'd9, 32'd999999999});
    vecs.push_back('{1'b1, 4'd5, 0, 0, 0, 4'd9, 32'd999999999});
    vecs.push_back('{1'b1, 4'hB, 0, 0, 0, 4'd9, 32'd999999999});
    vecs.push_back('{1'b1, 4'd3, 0, 0, 0, 4'd9, 32'd999999999});
    vecs.push_back('{1'b1, 4'hA, 0, 1, 0, 4'd9, 32'd3});
    vecs.push_back('{1'b1, 4'd8, 0, 0, 0, 4'd9, 32'd3});
    vecs.push_back('{1'b0, 4'hF, 0, 0, 0, 4'd9, 32'd3});
    vecs.push_back('{1'b1, 4'hA, 0, 0, 0, 4'd9, 32'd3});
    vecs.push_back('{1'b0, 4'd5, 1, 0, 0, 4'd5, 32'd3});

    RESET = 1'b0; TECLA_PRESIONADA = 1'b0; TECLA = 4'd0; MODO_MONTO = 1'b0;
    step(); step();
    RESET = 1'b1;
    step();
    chk("reset_digito_stb", 32'(DIGITO_STB), 32'd0);
    chk("reset_digito",     32'(DIGITO),     32'd0);
    chk("reset_monto_stb",  32'(MONTO_STB),  32'd0);
    chk("reset_monto",      MONTO,           32'd0);
    chk("reset_desborde",   32'(DESBORDE),   32'd0);

    // latency: key 7 held 10 cycles, one strobe on the 4th sampled cycle
    nd = 0; first = 0;
    TECLA = 4'd7; TECLA_PRESIONADA = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (DIGITO_STB) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    TECLA_PRESIONADA = 1'b0;
    repeat (DEB + 2) begin step(); nd += int'(DIGITO_STB); end
    chk("latency_count", 32'(nd), 32'd1);
    chk("latency_cycle", 32'(first), 32'd4);
    chk("latency_digito", 32'(DIGITO), 32'd7);

    // bounce: high 2, low 1, high 6, then a 1-cycle glitch while held
    nd = 0; first = 0;
    TECLA = 4'd3; TECLA_PRESIONADA = 1'b1;
    repeat (2) begin step(); nd += int'(DIGITO_STB); end
    TECLA_PRESIONADA = 1'b0;
    step(); nd += int'(DIGITO_STB);
    TECLA_PRESIONADA = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (DIGITO_STB) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    TECLA_PRESIONADA = 1'b0;
    step(); nd += int'(DIGITO_STB);
    TECLA_PRESIONADA = 1'b1;
    repeat (3) begin step(); nd += int'(DIGITO_STB); end
    TECLA_PRESIONADA = 1'b0;
    repeat (DEB + 2) begin step(); nd += int'(DIGITO_STB); end
    chk("bounce_count", 32'(nd), 32'd1);
    chk("bounce_cycle", 32'(first), 32'd4);
    chk("bounce_digito", 32'(DIGITO), 32'd3);

    foreach (vecs[i]) begin
      press(vecs[i].modo, vecs[i].tecla, 6, nd, nm, no);
      chk($sformatf("vec%0d_digito_stb", i), 32'(nd), 32'(vecs[i].nd));
      chk($sformatf("vec%0d_monto_stb", i),  32'(nm), 32'(vecs[i].nm));
      chk($sformatf("vec%0d_desborde", i),   32'(no), 32'(vecs[i].no));
      chk($sformatf("vec%0d_digito", i),     32'(DIGITO), 32'(vecs[i].dig));
      chk($sformatf("vec%0d_monto", i),      MONTO, vecs[i].monto);
    end

    // reset while key 5 is in the filter, then release: no strobe afterwards
    nd = 0;
    MODO_MONTO = 1'b0; TECLA = 4'd5; TECLA_PRESIONADA = 1'b1;
    step(); step();
    RESET = 1'b0;
    step(); step();
    chk("midreset_digito", 32'(DIGITO), 32'd0);
    chk("midreset_monto",  MONTO,       32'd0);
    chk("midreset_stb",    32'(DIGITO_STB) + 32'(MONTO_STB) + 32'(DESBORDE), 32'd0);
    TECLA_PRESIONADA = 1'b0;
    RESET = 1'b1;
    repeat (8) begin step(); nd += int'(DIGITO_STB); end
    chk("midreset_no_event", 32'(nd), 32'd0);
    press(1'b0, 4'd5, 6, nd, nm, no);
    chk("after_reset_count", 32'(nd), 32'd1);
    chk("after_reset_digito", 32'(DIGITO), 32'd5);

    chk("one_strobe_per_cycle", 32'(multi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
